ro_puf_array: RTL

- Parametrised array of NUM_RO enable-gated ring oscillators, each a NAND stage plus NUM_STAGES-1 inverters, with every internal net marked dont_touch.
- A clk-domain measurement engine enables one selected pair of oscillators for a fixed window and counts the rising edges of each.
- It compares the two counts and returns one PUF response bit plus the raw counts.
- The block sits between the oscillator fabric and the challenge/response controller of the delay-based PUF.

---
 rtl/ro_puf_array_if.sv | 28 ++
 rtl/ro_puf_array.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_array_if.sv
// Challenge/response bus between the PUF controller (master) and the
// ring-oscillator measurement engine (slave).
interface ro_puf_array_if #(
  parameter int unsigned SEL_WIDTH = 3,
  parameter int unsigned CNT_WIDTH = 16
) ();
  logic                 start;
  logic [SEL_WIDTH-1:0] sel_a;
  logic [SEL_WIDTH-1:0] sel_b;
  logic                 busy;
  logic                 done;
  logic                 response;
  logic                 tie;
  logic                 sat;
  logic                 error;
  logic [CNT_WIDTH-1:0] count_a;
  logic [CNT_WIDTH-1:0] count_b;

  modport master (
    output start, sel_a, sel_b,
    input  busy, done, response, tie, sat, error, count_a, count_b
  );

  modport slave (
    input  start, sel_a, sel_b,
    output busy, done, response, tie, sat, error, count_a, count_b
  );
endinterface

// File: rtl/ro_puf_array.sv
// Ring-oscillator PUF array: enables one challenge-selected pair of rings for a
// fixed window, counts edges of each in the clk domain and compares the counts.
module ro_puf_array #(
  parameter int unsigned NUM_RO        = 8,
  parameter int unsigned NUM_STAGES    = 7,
  parameter int unsigned SEL_WIDTH     = 3,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned WINDOW_CYCLES = 4096,
  parameter int unsigned USE_EXT_RO    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RO-1:0] ro_ext,
  ro_puf_array_if.slave     bus
);

  localparam int unsigned SRC_W = 1 << SEL_WIDTH;
  localparam int unsigned WIN_W = (WINDOW_CYCLES > 4) ? $clog2(WINDOW_CYCLES) : 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_COMPARE, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [NUM_RO-1:0]    en_q, en_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [2:0]           sync_a_q, sync_a_d, sync_b_q, sync_b_d;
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic                 sat_int_q, sat_int_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 response_q, response_d, tie_q, tie_d;
  logic                 sat_q, sat_d, error_q, error_d;
  logic [CNT_WIDTH-1:0] count_a_q, count_a_d, count_b_q, count_b_d;

  logic [NUM_RO-1:0]    ro_out;
  logic [SRC_W-1:0]     src_pad;
  logic                 src_a, src_b, edge_a, edge_b, legal, count_en;

  // Oscillation sources; a disabled source rests at 1 so enabling never fakes an edge.
  if (USE_EXT_RO != 0) begin : g_ext
    assign ro_out = ro_ext | ~en_q;
  end else begin : g_ring
    logic unused_ext;
    assign unused_ext = ^ro_ext;
    for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
      (* dont_touch = "true" *) logic [NUM_STAGES-1:0] stage;
      assign stage[0] = ~(en_q[i] & stage[NUM_STAGES-1]);
      for (genvar j = 1; j < NUM_STAGES; j++) begin : g_inv
        assign stage[j] = ~stage[j-1];
      end
      assign ro_out[i] = stage[NUM_STAGES-1];
    end
  end

  assign src_pad = SRC_W'(ro_out);
  assign src_a   = src_pad[sel_a_q];
  assign src_b   = src_pad[sel_b_q];
  assign edge_a  = sync_a_q[1] & ~sync_a_q[2];
  assign edge_b  = sync_b_q[1] & ~sync_b_q[2];
  assign legal   = (sel_a_q != sel_b_q) && (32'(sel_a_q) < NUM_RO) && (32'(sel_b_q) < NUM_RO);

  // Next-state, counters and result registers.
  always_comb begin
    state_d    = state_q;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    en_d       = en_q;
    win_d      = win_q;
    sync_a_d   = {sync_a_q[1:0], src_a};
    sync_b_d   = {sync_b_q[1:0], src_b};
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    sat_int_d  = sat_int_q;
    done_d     = 1'b0;
    response_d = response_q;
    tie_d      = tie_q;
    sat_d      = sat_q;
    error_d    = error_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
    count_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sel_a_d = bus.sel_a;
          sel_b_d = bus.sel_b;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!legal) begin
          error_d    = 1'b1;
          response_d = 1'b0;
          tie_d      = 1'b0;
          sat_d      = 1'b0;
          count_a_d  = '0;
          count_b_d  = '0;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_a_d   = '0;
          cnt_b_d   = '0;
          sat_int_d = 1'b0;
          win_d     = '0;
          en_d      = (NUM_RO'(1) << sel_a_q) | (NUM_RO'(1) << sel_b_q);
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        count_en = 1'b1;
        win_d    = win_q + WIN_W'(1);
        if (win_q == WIN_W'(WINDOW_CYCLES - 1)) begin
          en_d    = '0;
          win_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Drains edges still travelling through the synchronisers.
        count_en = 1'b1;
        win_d    = win_q + WIN_W'(1);
        if (win_q == WIN_W'(2)) begin
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        count_a_d  = cnt_a_q;
        count_b_d  = cnt_b_q;
        response_d = cnt_a_q > cnt_b_q;
        tie_d      = cnt_a_q == cnt_b_q;
        sat_d      = sat_int_q;
        error_d    = 1'b0;
        done_d     = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (count_en) begin
      if (edge_a) begin
        if (cnt_a_q == '1) sat_int_d = 1'b1;
        else               cnt_a_d   = cnt_a_q + CNT_WIDTH'(1);
      end
      if (edge_b) begin
        if (cnt_b_q == '1) sat_int_d = 1'b1;
        else               cnt_b_d   = cnt_b_q + CNT_WIDTH'(1);
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      en_q       <= '0;
      win_q      <= '0;
      sync_a_q   <= '1;
      sync_b_q   <= '1;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      sat_int_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= 1'b0;
      tie_q      <= 1'b0;
      sat_q      <= 1'b0;
      error_q    <= 1'b0;
      count_a_q  <= '0;
      count_b_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      en_q       <= en_d;
      win_q      <= win_d;
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      sat_int_q  <= sat_int_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      response_q <= response_d;
      tie_q      <= tie_d;
      sat_q      <= sat_d;
      error_q    <= error_d;
      count_a_q  <= count_a_d;
      count_b_q  <= count_b_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.response = response_q;
  assign bus.tie      = tie_q;
  assign bus.sat      = sat_q;
  assign bus.error    = error_q;
  assign bus.count_a  = count_a_q;
  assign bus.count_b  = count_b_q;

endmodule
